// File: rtl/alu_wb_stage.sv
// ALU write-back stage: registers the ALU result behind a valid/ready handshake,
// maintains the {C,N,Z,V,E,G} flag register, and evaluates branch conditions.
module alu_wb_stage #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_cmd,
    input  logic [DW-1:0]    rslt,
    input  logic             sc_o,
    input  logic             n_i,
    input  logic             z_i,
    input  logic             v_i,
    input  logic             e_i,
    input  logic             g_i,
    input  logic [AW-1:0]    dest_i,
    input  logic             wr_en_i,
    input  logic             flag_we,
    input  logic             carry_clr,
    output logic             sc_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [AW-1:0]    out_dest,
    output logic             out_wr,
    output logic [5:0]       flags,
    input  logic [2:0]       br_cond,
    output logic             br_take,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q,  out_data_d;
    logic [AW-1:0]    out_dest_q,  out_dest_d;
    logic             out_wr_q,    out_wr_d;
    logic [5:0]       flags_q,     flags_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;

    logic             accept_s;
    logic             c_upd_s;
    logic             c_d;
    logic [4:0]       nzveg_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // Output register, flag register and op counter next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_dest_d  = out_dest_q;
        out_wr_d    = out_wr_q;
        op_count_d  = op_count_q;
        nzveg_d     = flags_q[4:0];
        c_upd_s     = 1'b0;
        c_d         = flags_q[5];

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = rslt;
            out_dest_d  = dest_i;
            out_wr_d    = wr_en_i;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // nzveg_d bit order is {N,Z,V,E,G}
        if (accept_s && flag_we) begin
            case (alu_cmd)
                3'b000: begin
                    c_upd_s      = 1'b1;
                    nzveg_d[4:2] = {n_i, z_i, v_i};
                end
                3'b001, 3'b010: begin
                    c_upd_s      = 1'b1;
                    nzveg_d[4:3] = {n_i, z_i};
                end
                3'b011, 3'b100, 3'b110: begin
                    nzveg_d[4:3] = {n_i, z_i};
                end
                3'b101: begin
                    c_upd_s = 1'b1;
                    nzveg_d = {n_i, z_i, v_i, e_i, g_i};
                end
                default: begin
                    nzveg_d = flags_q[4:0];
                end
            endcase
        end else begin
            nzveg_d = flags_q[4:0];
        end

        // An op that writes C takes priority over a chain-start clear.
        if (c_upd_s) begin
            c_d = sc_o;
        end else if (carry_clr) begin
            c_d = 1'b0;
        end else begin
            c_d = flags_q[5];
        end
        flags_d = {c_d, nzveg_d};

        if (accept_s && (op_count_q != CNT_MAX)) begin
            op_count_d = op_count_q + CNT_W'(1);
        end else begin
            op_count_d = op_count_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            out_dest_q  <= {AW{1'b0}};
            out_wr_q    <= 1'b0;
            flags_q     <= 6'b000000;
            op_count_q  <= {CNT_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
            out_wr_q    <= out_wr_d;
            flags_q     <= flags_d;
            op_count_q  <= op_count_d;
        end
    end

    // Branch condition decode on the registered flags.
    always_comb begin
        br_take = 1'b0;
        case (br_cond)
            3'b000:  br_take = 1'b1;
            3'b001:  br_take = flags_q[3];
            3'b010:  br_take = !flags_q[3];
            3'b011:  br_take = flags_q[5];
            3'b100:  br_take = flags_q[4];
            3'b101:  br_take = flags_q[2];
            3'b110:  br_take = flags_q[0];
            default: br_take = 1'b0;
        endcase
    end

    assign sc_i      = flags_q[5];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_dest  = out_dest_q;
    assign out_wr    = out_wr_q;
    assign flags     = flags_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Randomized and directed bench for alu_wb_stage against a behavioural
// model of the handshake, flag update table, branch decode and counter.
module tb_alu_wb_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] alu_cmd;
    logic [7:0] rslt;
    logic       sc_o, n_i, z_i, v_i, e_i, g_i;
    logic [2:0] dest_i;
    logic       wr_en_i, flag_we, carry_clr;
    logic       sc_i;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_dest;
    logic       out_wr;
    logic [5:0] flags;
    logic [2:0] br_cond;
    logic       br_take;
    logic [7:0] op_count;

    int vectors = 0;
    int miscompares = 0;

    alu_wb_stage #(.DW(8), .AW(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_cmd(alu_cmd), .rslt(rslt), .sc_o(sc_o), .n_i(n_i), .z_i(z_i),
        .v_i(v_i), .e_i(e_i), .g_i(g_i), .dest_i(dest_i), .wr_en_i(wr_en_i),
        .flag_we(flag_we), .carry_clr(carry_clr), .sc_i(sc_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .out_wr(out_wr), .flags(flags),
        .br_cond(br_cond), .br_take(br_take), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    bit       m_init = 1'b0;
    bit       m_valid;
    int       m_data, m_dest;
    bit       m_wr;
    bit       m_c, m_n, m_z, m_v, m_e, m_g;
    int       m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_br(input int cond);
        case (cond)
            0: return 1'b1;
            1: return m_z;
            2: return !m_z;
            3: return m_c;
            4: return m_n;
            5: return m_v;
            6: return m_g;
            default: return 1'b0;
        endcase
    endfunction

    // Model update at each rising edge from the stable inputs.
    always @(posedge clk) begin
        bit ready, acc, c_written;
        if (!rst_n) begin
            m_init = 1'b1;
            m_valid = 0; m_data = 0; m_dest = 0; m_wr = 0;
            {m_c, m_n, m_z, m_v, m_e, m_g} = 6'b0;
            m_cnt = 0;
        end else if (m_init) begin
            ready = !m_valid || out_ready;
            acc = in_valid && ready;
            c_written = 0;
            if (acc) begin
                m_valid = 1; m_data = int'(rslt); m_dest = int'(dest_i); m_wr = wr_en_i;
                if (flag_we) begin
                    if (alu_cmd == 0) begin
                        m_c = sc_o; c_written = 1; m_n = n_i; m_z = z_i; m_v = v_i;
                    end else if (alu_cmd == 1 || alu_cmd == 2) begin
                        m_c = sc_o; c_written = 1; m_n = n_i; m_z = z_i;
                    end else if (alu_cmd == 3 || alu_cmd == 4 || alu_cmd == 6) begin
                        m_n = n_i; m_z = z_i;
                    end else if (alu_cmd == 5) begin
                        m_c = sc_o; c_written = 1;
                        m_n = n_i; m_z = z_i; m_v = v_i; m_e = e_i; m_g = g_i;
                    end
                end
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (carry_clr && !c_written) m_c = 0;
        end
    end

    // Compare every falling edge once the model has seen a reset.
    always @(negedge clk) begin
        if (m_init) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("out_data", 32'(out_data), 32'(m_data));
                check("out_dest", 32'(out_dest), 32'(m_dest));
                check("out_wr",   32'(out_wr),   32'(m_wr));
            end
            check("flags",    32'(flags), 32'({m_c, m_n, m_z, m_v, m_e, m_g}));
            check("op_count", 32'(op_count), 32'(m_cnt));
            check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("sc_i",     32'(sc_i), 32'(m_c));
            check("br_take",  32'(br_take), 32'(model_br(int'(br_cond))));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        in_valid = 0; alu_cmd = 3'd7; rslt = 8'h00; sc_o = 0; n_i = 0; z_i = 0;
        v_i = 0; e_i = 0; g_i = 0; dest_i = 3'd0; wr_en_i = 0; flag_we = 1;
        carry_clr = 0; out_ready = 1; br_cond = 3'd0;
    endtask

    task automatic op(input logic [2:0] cmd, input logic [7:0] r, input logic c,
                      input logic n, input logic z, input logic v, input logic e, input logic g);
        in_valid = 1; alu_cmd = cmd; rslt = r; sc_o = c; n_i = n; z_i = z;
        v_i = v; e_i = e; g_i = g; dest_i = r[2:0]; wr_en_i = r[0];
    endtask

    task automatic do_reset();
        rst_n = 0;
        in_valid = 1;
        tick();
        tick();
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        #2;
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags",     32'(flags), 32'd0);
        check("rst_op_count",  32'(op_count), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_sc_i",      32'(sc_i), 32'd0);

        // Add chain
        op(3'b000, 8'h00, 1, 0, 1, 0, 0, 0);
        br_cond = 3'b001;
        tick();
        in_valid = 0;
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_out_data",  32'(out_data), 32'h00);
        check("add_flags",     32'(flags), 32'b101000);
        check("add_sc_i",      32'(sc_i), 32'd1);
        check("add_br_take",   32'(br_take), 32'd1);
        tick();

        // Backpressure
        do_reset();
        out_ready = 0;
        op(3'b011, 8'hA5, 0, 1, 0, 0, 0, 0);
        tick();
        op(3'b011, 8'h5A, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", 32'(out_data), 32'hA5);
            check("bp_op_count", 32'(op_count), 32'd1);
            tick();
        end
        out_ready = 1;
        tick();
        in_valid = 0;
        check("bp_release_data", 32'(out_data), 32'h5A);
        tick();

        // Throughput
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            op(3'b100, 8'(i), 0, 0, 0, 0, 0, 0);
            tick();
            check("tp_out_data", 32'(out_data), 32'(i));
        end
        in_valid = 0;
        check("tp_op_count", 32'(op_count), 32'd10);
        tick();

        // Flag masking
        op(3'b101, 8'h11, 1, 1, 0, 1, 1, 1);
        tick();
        check("cmp_flags", 32'(flags), 32'b110111);
        op(3'b011, 8'h22, 0, 0, 0, 0, 0, 0);
        tick();
        check("and_flags", 32'(flags), 32'b100111);
        flag_we = 0;
        op(3'b101, 8'h33, 0, 0, 0, 0, 0, 0);
        tick();
        check("nowe_flags", 32'(flags), 32'b100111);
        flag_we = 1;

        // Carry clear
        in_valid = 0;
        carry_clr = 1;
        tick();
        check("cclr_flags", 32'(flags), 32'b000111);
        op(3'b000, 8'h44, 1, 0, 0, 0, 0, 0);
        tick();
        check("cclr_add_flags", 32'(flags), 32'b100011);
        carry_clr = 0;

        // Saturation
        for (int i = 0; i < 300; i++) begin
            op(3'(i), 8'(i), 0, 0, 0, 0, 0, 0);
            tick();
        end
        in_valid = 0;
        check("sat_op_count", 32'(op_count), 32'hFF);
        tick();

        // Random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            alu_cmd   = 3'($urandom);
            rslt      = 8'($urandom);
            {sc_o, n_i, z_i, v_i, e_i, g_i} = 6'($urandom);
            dest_i    = 3'($urandom);
            wr_en_i   = 1'($urandom);
            flag_we   = ($urandom_range(0, 7) != 0);
            carry_clr = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            br_cond   = 3'($urandom);
            tick();
        end
        rst_n = 1;
        idle_inputs();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
